// File: rtl/nrs_rd_arbiter_if.sv
// Bundle of requester, shared NRS memory read port and returned-data signals for nrs_rd_arbiter.
// master drives requests and memory read data; slave is the arbiter itself.
interface nrs_rd_arbiter_if #(
    parameter int NRS_ADDR = 4
);
    logic                req_est;
    logic                req_meas;
    logic [NRS_ADDR-1:0] rd_addr_est;
    logic [NRS_ADDR-1:0] rd_addr_meas;
    logic                last_est;
    logic                last_meas;
    logic                nrs_r_mem;
    logic                nrs_i_mem;
    logic                rd_en_nrs;
    logic [NRS_ADDR-1:0] rd_addr_nrs;
    logic                gnt_est;
    logic                gnt_meas;
    logic                nrs_r_est;
    logic                nrs_i_est;
    logic                vld_est;
    logic                nrs_r_meas;
    logic                nrs_i_meas;
    logic                vld_meas;

    modport master (
        output req_est, req_meas, rd_addr_est, rd_addr_meas, last_est, last_meas,
        output nrs_r_mem, nrs_i_mem,
        input  rd_en_nrs, rd_addr_nrs, gnt_est, gnt_meas,
        input  nrs_r_est, nrs_i_est, vld_est, nrs_r_meas, nrs_i_meas, vld_meas
    );

    modport slave (
        input  req_est, req_meas, rd_addr_est, rd_addr_meas, last_est, last_meas,
        input  nrs_r_mem, nrs_i_mem,
        output rd_en_nrs, rd_addr_nrs, gnt_est, gnt_meas,
        output nrs_r_est, nrs_i_est, vld_est, nrs_r_meas, nrs_i_meas, vld_meas
    );
endinterface

// File: rtl/nrs_rd_arbiter.sv
// Arbitrates the shared NRS value memory read port between channel estimation and RSRP measurement.
// Define NRS_ARB_FIXED_PRIO_EN for fixed est-over-meas priority; default is round-robin.
module nrs_rd_arbiter #(
    parameter int NRS_ADDR = 4
) (
    input  logic               clk,
    input  logic               rst,
    nrs_rd_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {IDLE, G_EST, G_MEAS} state_t;

    localparam logic SERVED_EST  = 1'b0;
    localparam logic SERVED_MEAS = 1'b1;

    state_t              state;
    state_t              state_next;
    logic                last_served;
    logic [4:0]          beat_cnt;
    logic                gnt_est;
    logic                gnt_meas;
    logic                beat_est;
    logic                beat_meas;
    logic                sixteenth_beat;
    logic                release_est;
    logic                release_meas;
    logic                est_wins;
    logic                grant_entry;
    logic                vld_est;
    logic                vld_meas;
    logic [NRS_ADDR-1:0] addr_mux;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Release ends a grant; the handover goes straight to the waiting requester without an idle bubble.
    always_comb begin
        state_next     = state;
        release_est    = 1'b0;
        release_meas   = 1'b0;
        sixteenth_beat = (beat_cnt == 5'd15);
`ifdef NRS_ARB_FIXED_PRIO_EN
        est_wins       = 1'b1;
`else
        est_wins       = (last_served == SERVED_MEAS);
`endif
        case (state)
            IDLE: begin
                if (bus.req_est && bus.req_meas) begin
                    state_next = est_wins ? G_EST : G_MEAS;
                end else if (bus.req_est) begin
                    state_next = G_EST;
                end else if (bus.req_meas) begin
                    state_next = G_MEAS;
                end
            end
            G_EST: begin
                release_est = !bus.req_est || (beat_est && (bus.last_est || sixteenth_beat));
                if (release_est) begin
`ifdef NRS_ARB_FIXED_PRIO_EN
                    state_next = (bus.req_meas && !bus.req_est) ? G_MEAS : IDLE;
`else
                    state_next = bus.req_meas ? G_MEAS : IDLE;
`endif
                end
            end
            G_MEAS: begin
                release_meas = !bus.req_meas || (beat_meas && (bus.last_meas || sixteenth_beat));
                if (release_meas) begin
                    state_next = bus.req_est ? G_EST : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        grant_entry = (state_next != state) && (state_next != IDLE);
    end

    always_comb begin
        gnt_est   = (state == G_EST);
        gnt_meas  = (state == G_MEAS);
        beat_est  = gnt_est && bus.req_est;
        beat_meas = gnt_meas && bus.req_meas;
        addr_mux  = '0;
        if (gnt_est) begin
            addr_mux = bus.rd_addr_est;
        end else if (gnt_meas) begin
            addr_mux = bus.rd_addr_meas;
        end
        bus.gnt_est     = gnt_est;
        bus.gnt_meas    = gnt_meas;
        bus.rd_en_nrs   = (beat_est || beat_meas) && !rst;
        bus.rd_addr_nrs = addr_mux;
        bus.vld_est     = vld_est;
        bus.vld_meas    = vld_meas;
        bus.nrs_r_est   = vld_est  ? bus.nrs_r_mem : 1'b0;
        bus.nrs_i_est   = vld_est  ? bus.nrs_i_mem : 1'b0;
        bus.nrs_r_meas  = vld_meas ? bus.nrs_r_mem : 1'b0;
        bus.nrs_i_meas  = vld_meas ? bus.nrs_i_mem : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_served <= SERVED_MEAS;
        end else if (release_est) begin
            last_served <= SERVED_EST;
        end else if (release_meas) begin
            last_served <= SERVED_MEAS;
        end
    end

    // Holds the final count after a release to IDLE; cleared only when a grant is entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= 5'd0;
        end else if (grant_entry) begin
            beat_cnt <= 5'd0;
        end else if (beat_est || beat_meas) begin
            beat_cnt <= beat_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_est  <= 1'b0;
            vld_meas <= 1'b0;
        end else begin
            vld_est  <= beat_est;
            vld_meas <= beat_meas;
        end
    end
endmodule
